// File: rtl/wb_ram_pkg.sv
// rtl/wb_ram_pkg.sv - shared types, constants and byte-merge helper for the dual-port Wishbone RAM
package wb_ram_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_ram_state_e;

  // Replace only the byte lanes whose enable bit is set; be=0 leaves the word untouched
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_ram_dp_if.sv
// rtl/wb_ram_dp_if.sv - bus bundle for the instruction (A) and data (B) Wishbone ports
interface wb_ram_dp_if #(
  parameter int ADR_W = 30
);
  // Port A: read-only instruction port, no write enable
  logic             a_cyc_i;
  logic             a_stb_i;
  logic [ADR_W-1:0] a_adr_i;
  logic             a_ack_o;
  logic             a_err_o;
  logic [31:0]      a_dat_o;

  // Port B: read/write data port
  logic             b_cyc_i;
  logic             b_stb_i;
  logic             b_we_i;
  logic [3:0]       b_be_i;
  logic [ADR_W-1:0] b_adr_i;
  logic [31:0]      b_dat_i;
  logic             b_ack_o;
  logic             b_err_o;
  logic [31:0]      b_dat_o;

  modport master (
    output a_cyc_i, a_stb_i, a_adr_i,
    input  a_ack_o, a_err_o, a_dat_o,
    output b_cyc_i, b_stb_i, b_we_i, b_be_i, b_adr_i, b_dat_i,
    input  b_ack_o, b_err_o, b_dat_o
  );

  modport slave (
    input  a_cyc_i, a_stb_i, a_adr_i,
    output a_ack_o, a_err_o, a_dat_o,
    input  b_cyc_i, b_stb_i, b_we_i, b_be_i, b_adr_i, b_dat_i,
    output b_ack_o, b_err_o, b_dat_o
  );

endinterface

// File: rtl/wb_ram_port_ctrl.sv
// rtl/wb_ram_port_ctrl.sv - per-port handshake FSM, latency counter and address range check
module wb_ram_port_ctrl
  import wb_ram_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADR_W   = 30,
  parameter int LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cyc,
  input  logic             i_stb,
  input  logic [ADR_W-1:0] i_adr,
  output logic             o_complete,
  output logic             o_in_range
);

  // Counter preload; zero means the request completes at the sampling edge itself
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(LATENCY - 1);
  localparam logic [ADR_W:0]   DEPTH_LIM = (ADR_W + 1)'(DEPTH);

  wb_ram_state_e    r_state;
  wb_ram_state_e    w_state_nxt;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_nxt;
  logic             w_req;

  assign w_req      = i_cyc & i_stb;
  assign o_in_range = ({1'b0, i_adr} < DEPTH_LIM);

  // State and latency counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and completion strobe; completion is the edge at which the counter reaches zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (LAT_LOAD == '0) begin
            o_complete  = i_rst_n;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAT_W'(1)) begin
          o_complete  = i_rst_n;
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - LAT_W'(1);
        end
      end
      RESP: begin
        // A strobe still held here belongs to the finished access, not a new one
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/wb_ram_dp.sv
// rtl/wb_ram_dp.sv - dual-port Wishbone RAM with programmable latency and out-of-range bus error
module wb_ram_dp
  import wb_ram_pkg::*;
#(
  parameter int    DEPTH   = 256,
  parameter int    ADR_W   = 30,
  parameter int    LATENCY = 1,
  parameter string MEMFILE = ""
) (
  input  logic       clk_i,
  input  logic       rst_in,
  wb_ram_dp_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      r_mem [DEPTH];

  logic             w_a_complete;
  logic             w_a_in_range;
  logic             w_b_complete;
  logic             w_b_in_range;
  logic [IDX_W-1:0] w_a_idx;
  logic [IDX_W-1:0] w_b_idx;

  logic             r_a_ack;
  logic             r_a_err;
  logic [31:0]      r_a_dat;
  logic             r_b_ack;
  logic             r_b_err;
  logic [31:0]      r_b_dat;

  assign w_a_idx = bus.a_adr_i[IDX_W-1:0];
  assign w_b_idx = bus.b_adr_i[IDX_W-1:0];

  wb_ram_port_ctrl #(
    .DEPTH   (DEPTH),
    .ADR_W   (ADR_W),
    .LATENCY (LATENCY)
  ) u_ctrl_a (
    .i_clk      (clk_i),
    .i_rst_n    (rst_in),
    .i_cyc      (bus.a_cyc_i),
    .i_stb      (bus.a_stb_i),
    .i_adr      (bus.a_adr_i),
    .o_complete (w_a_complete),
    .o_in_range (w_a_in_range)
  );

  wb_ram_port_ctrl #(
    .DEPTH   (DEPTH),
    .ADR_W   (ADR_W),
    .LATENCY (LATENCY)
  ) u_ctrl_b (
    .i_clk      (clk_i),
    .i_rst_n    (rst_in),
    .i_cyc      (bus.b_cyc_i),
    .i_stb      (bus.b_stb_i),
    .i_adr      (bus.b_adr_i),
    .o_complete (w_b_complete),
    .o_in_range (w_b_in_range)
  );

  // Port B byte-enable write; the array itself is never reset
  always_ff @(posedge clk_i) begin
    if (w_b_complete && w_b_in_range && bus.b_we_i) begin
      r_mem[w_b_idx] <= be_merge(r_mem[w_b_idx], bus.b_dat_i, bus.b_be_i);
    end
  end

  // Port A response: read-before-write against a same-edge port B write falls out of the NBA ordering
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_a_ack <= 1'b0;
      r_a_err <= 1'b0;
      r_a_dat <= '0;
    end else begin
      r_a_ack <= w_a_complete & w_a_in_range;
      r_a_err <= w_a_complete & ~w_a_in_range;
      if (w_a_complete) begin
        r_a_dat <= w_a_in_range ? r_mem[w_a_idx] : 32'h0;
      end
    end
  end

  // Port B response: read data only changes on a completed read or an error
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_b_ack <= 1'b0;
      r_b_err <= 1'b0;
      r_b_dat <= '0;
    end else begin
      r_b_ack <= w_b_complete & w_b_in_range;
      r_b_err <= w_b_complete & ~w_b_in_range;
      if (w_b_complete) begin
        if (!w_b_in_range) begin
          r_b_dat <= 32'h0;
        end else if (!bus.b_we_i) begin
          r_b_dat <= r_mem[w_b_idx];
        end
      end
    end
  end

  assign bus.a_ack_o = r_a_ack;
  assign bus.a_err_o = r_a_err;
  assign bus.a_dat_o = r_a_dat;
  assign bus.b_ack_o = r_b_ack;
  assign bus.b_err_o = r_b_err;
  assign bus.b_dat_o = r_b_dat;

endmodule

// File: tb/tb_wb_ram_dp.sv
// tb/tb_wb_ram_dp.sv - self-checking bench for wb_ram_dp at latencies 1, 3 and 4
module tb_wb_ram_dp;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n4;

  always #5 clk = ~clk;

  wb_ram_dp_if #(.ADR_W(30)) if1 ();
  wb_ram_dp_if #(.ADR_W(30)) if3 ();
  wb_ram_dp_if #(.ADR_W(30)) if4 ();

  wb_ram_dp #(.DEPTH(256), .ADR_W(30), .LATENCY(1), .MEMFILE("")) dut1 (
    .clk_i (clk), .rst_in (rst_n), .bus (if1));
  wb_ram_dp #(.DEPTH(256), .ADR_W(30), .LATENCY(3), .MEMFILE("")) dut3 (
    .clk_i (clk), .rst_in (rst_n), .bus (if3));
  wb_ram_dp #(.DEPTH(256), .ADR_W(30), .LATENCY(4), .MEMFILE("")) dut4 (
    .clk_i (clk), .rst_in (rst_n4), .bus (if4));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          p;        // 0 = port A, 1 = port B
    logic        we;
    logic [3:0]  be;
    logic [29:0] adr;
    logic [31:0] wdat;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] sb[$];

  logic        s_ack, s_err, t_ack, t_err, ok_ack, got_err, ack_after, seen;
  logic [31:0] s_dat, t_dat, got_dat, exp_q;
  int          lat;
  logic [15:0] b2b_ack, b2b_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit p, input logic cyc, input logic we,
                       input logic [3:0] be, input logic [29:0] adr, input logic [31:0] dat);
    case (sel)
      1: if (p) begin
           if1.b_cyc_i = cyc; if1.b_stb_i = cyc; if1.b_we_i = we;
           if1.b_be_i = be; if1.b_adr_i = adr; if1.b_dat_i = dat;
         end else begin
           if1.a_cyc_i = cyc; if1.a_stb_i = cyc; if1.a_adr_i = adr;
         end
      3: if (p) begin
           if3.b_cyc_i = cyc; if3.b_stb_i = cyc; if3.b_we_i = we;
           if3.b_be_i = be; if3.b_adr_i = adr; if3.b_dat_i = dat;
         end else begin
           if3.a_cyc_i = cyc; if3.a_stb_i = cyc; if3.a_adr_i = adr;
         end
      default: if (p) begin
           if4.b_cyc_i = cyc; if4.b_stb_i = cyc; if4.b_we_i = we;
           if4.b_be_i = be; if4.b_adr_i = adr; if4.b_dat_i = dat;
         end else begin
           if4.a_cyc_i = cyc; if4.a_stb_i = cyc; if4.a_adr_i = adr;
         end
    endcase
  endtask

  task automatic get(input int sel, input bit p, output logic ack, output logic err,
                     output logic [31:0] dat);
    case (sel)
      1: if (p) {ack, err, dat} = {if1.b_ack_o, if1.b_err_o, if1.b_dat_o};
         else   {ack, err, dat} = {if1.a_ack_o, if1.a_err_o, if1.a_dat_o};
      3: if (p) {ack, err, dat} = {if3.b_ack_o, if3.b_err_o, if3.b_dat_o};
         else   {ack, err, dat} = {if3.a_ack_o, if3.a_err_o, if3.a_dat_o};
      default: if (p) {ack, err, dat} = {if4.b_ack_o, if4.b_err_o, if4.b_dat_o};
         else   {ack, err, dat} = {if4.a_ack_o, if4.a_err_o, if4.a_dat_o};
    endcase
  endtask

  // One bus access: lat = edges from the sampling edge to the response (0 on timeout)
  task automatic xfer(input int sel, input bit p, input logic we, input logic [3:0] be,
                      input logic [29:0] adr, input logic [31:0] dat,
                      output logic o_ack, output logic o_err, output logic [31:0] o_dat,
                      output int o_lat, output logic o_after);
    logic a, e;
    logic [31:0] d;
    @(negedge clk);
    drive(sel, p, 1'b1, we, be, adr, dat);
    o_lat = 0; o_ack = 1'b0; o_err = 1'b0; o_dat = '0;
    for (int k = 1; k <= 32 && o_lat == 0; k++) begin
      @(posedge clk); #1;
      get(sel, p, a, e, d);
      if (a || e) begin
        o_lat = k; o_ack = a; o_err = e; o_dat = d;
      end
    end
    drive(sel, p, 1'b0, 1'b0, 4'h0, adr, dat);
    @(posedge clk); #1;
    get(sel, p, a, e, d);
    o_after = a | e;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_n4 = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      drive(s, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
      drive(s, 1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    get(1, 1'b0, s_ack, s_err, s_dat); chk("rst_a1", {s_ack, s_err, s_dat}, 0);
    get(1, 1'b1, s_ack, s_err, s_dat); chk("rst_b1", {s_ack, s_err, s_dat}, 0);
    get(4, 1'b1, s_ack, s_err, s_dat); chk("rst_b4", {s_ack, s_err, s_dat}, 0);
    @(negedge clk);
    rst_n = 1'b1; rst_n4 = 1'b1;

    // Table-driven accesses on the LATENCY=1 instance
    vt.push_back('{1'b1, 1'b1, 4'hF, 30'h10,  32'hDEADBEEF, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b0, 4'h0, 30'h10,  32'h0,        1'b0, 32'hDEADBEEF});
    vt.push_back('{1'b1, 1'b1, 4'hF, 30'h5,   32'hAABBCCDD, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b1, 4'h5, 30'h5,   32'h11223344, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b0, 4'hF, 30'h5,   32'h0,        1'b0, 32'hAA22CC44});
    vt.push_back('{1'b1, 1'b1, 4'h0, 30'h5,   32'hFFFFFFFF, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b0, 4'h0, 30'h5,   32'h0,        1'b0, 32'hAA22CC44});
    vt.push_back('{1'b1, 1'b1, 4'hF, 30'h0,   32'h12345678, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b1, 4'hF, 30'd256, 32'hFFFFFFFF, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b0, 4'hF, 30'h0,   32'h0,        1'b0, 32'h12345678});
    vt.push_back('{1'b0, 1'b0, 4'h0, 30'd300, 32'h0,        1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b1, 4'hF, 30'd255, 32'hCAFEF00D, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b0, 4'h0, 30'd255, 32'h0,        1'b0, 32'hCAFEF00D});
    vt.push_back('{1'b0, 1'b0, 4'h0, 30'h10,  32'h0,        1'b0, 32'hDEADBEEF});

    for (int i = 0; i < vt.size(); i++) begin
      if (!vt[i].we || vt[i].exp_err) sb.push_back(vt[i].exp_dat);
      xfer(1, vt[i].p, vt[i].we, vt[i].be, vt[i].adr, vt[i].wdat,
           ok_ack, got_err, got_dat, lat, ack_after);
      chk($sformatf("row%0d_lat", i), lat, 1);
      chk($sformatf("row%0d_resp", i), {ok_ack, got_err}, vt[i].exp_err ? 2'b01 : 2'b10);
      chk($sformatf("row%0d_pulse", i), ack_after, 0);
      if (((ok_ack && !vt[i].we) || got_err) && sb.size() > 0) begin
        exp_q = sb.pop_front();
        chk($sformatf("row%0d_dat", i), got_dat, exp_q);
      end
    end

    // Same-edge A read and B write to one address: A sees the old word
    xfer(1, 1'b1, 1'b1, 4'hF, 30'h8, 32'h1, ok_ack, got_err, got_dat, lat, ack_after);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1'b0, 4'h0, 30'h8, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b1, 4'hF, 30'h8, 32'h2);
    @(posedge clk); #1;
    get(1, 1'b0, s_ack, s_err, s_dat);
    get(1, 1'b1, t_ack, t_err, t_dat);
    chk("same_edge_acks", {s_ack, t_ack}, 2'b11);
    chk("same_edge_a_old", s_dat, 32'h1);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h8, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 30'h8, 32'h0);
    xfer(1, 1'b0, 1'b0, 4'h0, 30'h8, 32'h0, ok_ack, got_err, got_dat, lat, ack_after);
    chk("same_edge_a_new", got_dat, 32'h2);

    // LATENCY=3: single access latency, then back-to-back strobe throughput
    xfer(3, 1'b1, 1'b1, 4'hF, 30'h7, 32'h0BADCAFE, ok_ack, got_err, got_dat, lat, ack_after);
    chk("lat3_lat", lat, 3);
    chk("lat3_pulse", ack_after, 0);
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 1'b0, 4'hF, 30'h7, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      get(3, 1'b1, s_ack, s_err, s_dat);
      b2b_ack[k-1] = s_ack;
      b2b_exp[k-1] = ((k % 4) == 3);
      if (s_ack) chk($sformatf("b2b_dat%0d", k), s_dat, 32'h0BADCAFE);
    end
    drive(3, 1'b1, 1'b0, 1'b0, 4'h0, 30'h7, 32'h0);
    chk("b2b_ack_pattern", b2b_ack, b2b_exp);

    // LATENCY=4: abort by dropping cyc in WAIT, then reset mid-WAIT
    xfer(4, 1'b1, 1'b1, 4'hF, 30'd20, 32'h00000055, ok_ack, got_err, got_dat, lat, ack_after);
    chk("lat4_lat", lat, 4);
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 1'b1, 4'hF, 30'd20, 32'h00000099);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if4.b_cyc_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      get(4, 1'b1, s_ack, s_err, s_dat);
      seen = seen | s_ack | s_err;
    end
    chk("abort_no_resp", seen, 0);
    drive(4, 1'b1, 1'b0, 1'b0, 4'h0, 30'd20, 32'h0);
    xfer(4, 1'b1, 1'b0, 4'hF, 30'd20, 32'h0, ok_ack, got_err, got_dat, lat, ack_after);
    chk("abort_no_write", got_dat, 32'h55);

    @(negedge clk);
    drive(4, 1'b1, 1'b1, 1'b1, 4'hF, 30'd20, 32'h00000077);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n4 = 1'b0;
    #1;
    get(4, 1'b1, s_ack, s_err, s_dat);
    chk("rst_mid_wait_out", {s_ack, s_err, s_dat}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(4, 1'b1, 1'b0, 1'b0, 4'h0, 30'd20, 32'h0);
    rst_n4 = 1'b1;
    xfer(4, 1'b1, 1'b0, 4'hF, 30'd20, 32'h0, ok_ack, got_err, got_dat, lat, ack_after);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_no_write", got_dat, 32'h55);
    xfer(4, 1'b0, 1'b0, 4'h0, 30'd20, 32'h0, ok_ack, got_err, got_dat, lat, ack_after);
    chk("post_rst_a", {ok_ack, got_dat}, {1'b1, 32'h55});

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
